// File: rtl/conv_run_if.sv
// Handshake bundle between the convolution run sequencer and the memory/engine side.
// All strobes and done signals are single-cycle pulses sampled on the rising clock edge; there is no back-pressure.
interface conv_run_if;
    logic       start;
    logic [2:0] engine_en;
    logic       done_capture;
    logic       pe_done;
    logic       sa3_done;
    logic       sa2_done;
    logic       run_valid_o;
    logic       pe_start;
    logic       sa3_start;
    logic       sa2_start;
    logic [1:0] active_engine;
    logic       busy;
    logic       run_done;
    logic       timeout_err;
    logic [2:0] fsm_state;

    modport master (
        output start, engine_en, done_capture, pe_done, sa3_done, sa2_done,
        input  run_valid_o, pe_start, sa3_start, sa2_start, active_engine,
               busy, run_done, timeout_err, fsm_state
    );

    modport slave (
        input  start, engine_en, done_capture, pe_done, sa3_done, sa2_done,
        output run_valid_o, pe_start, sa3_start, sa2_start, active_engine,
               busy, run_done, timeout_err, fsm_state
    );
endinterface

// File: rtl/conv_run_sequencer.sv
// Sequences one convolution run: memory capture, then PE / SA_3x3 / SA_2x2 one at a time,
// with a per-wait timeout that aborts the run and raises a sticky error.
module conv_run_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input logic       clk,
    input logic       reset,
    conv_run_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CAPTURE  = 3'd1,
        S_WAIT_CAP = 3'd2,
        S_LAUNCH   = 3'd3,
        S_WAIT_ENG = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [2:0]       mask, mask_nxt;
    logic [1:0]       eng, eng_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             err, err_nxt;
    logic [2:0]       pick;
    logic [1:0]       pick_code;
    logic             eng_done;
    logic             run_valid, run_done;
    logic [2:0]       starts;

    // Lowest remaining engine wins, giving the fixed PE -> SA_3x3 -> SA_2x2 order.
    assign pick = mask & (~mask + 3'd1);

    always_comb begin
        pick_code = 2'd0;
        case (pick)
            3'b001:  pick_code = 2'd1;
            3'b010:  pick_code = 2'd2;
            3'b100:  pick_code = 2'd3;
            default: pick_code = 2'd0;
        endcase
    end

    assign eng_done = ((eng == 2'd1) && bus.pe_done) ||
                      ((eng == 2'd2) && bus.sa3_done) ||
                      ((eng == 2'd3) && bus.sa2_done);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            mask  <= 3'b000;
            eng   <= 2'd0;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            mask  <= mask_nxt;
            eng   <= eng_nxt;
            cnt   <= cnt_nxt;
            err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mask_nxt  = mask;
        eng_nxt   = eng;
        cnt_nxt   = cnt;
        err_nxt   = err;
        run_valid = 1'b0;
        run_done  = 1'b0;
        starts    = 3'b000;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_CAPTURE;
                    mask_nxt  = bus.engine_en;
                    err_nxt   = 1'b0;
                end
            end
            S_CAPTURE: begin
                run_valid = 1'b1;
                cnt_nxt   = '0;
                state_nxt = S_WAIT_CAP;
            end
            S_WAIT_CAP: begin
                if (bus.done_capture) begin
                    state_nxt = (mask == 3'b000) ? S_DONE : S_LAUNCH;
                end else if (cnt == LAST) begin
                    err_nxt   = 1'b1;
                    eng_nxt   = 2'd0;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_LAUNCH: begin
                starts    = pick;
                eng_nxt   = pick_code;
                mask_nxt  = mask & ~pick;
                cnt_nxt   = '0;
                state_nxt = S_WAIT_ENG;
            end
            S_WAIT_ENG: begin
                // The awaited done takes priority over the terminal count.
                if (eng_done) begin
                    eng_nxt   = 2'd0;
                    state_nxt = (mask != 3'b000) ? S_LAUNCH : S_DONE;
                end else if (cnt == LAST) begin
                    err_nxt   = 1'b1;
                    eng_nxt   = 2'd0;
                    state_nxt = S_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_DONE: begin
                run_done  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.run_valid_o   = run_valid;
    assign bus.pe_start      = starts[0];
    assign bus.sa3_start     = starts[1];
    assign bus.sa2_start     = starts[2];
    assign bus.active_engine = eng;
    assign bus.busy          = (state != S_IDLE);
    assign bus.run_done      = run_done;
    assign bus.timeout_err   = err;
    assign bus.fsm_state     = state;
endmodule

// File: tb/tb_conv_run_sequencer.sv
// Directed bench for conv_run_sequencer: automatic memory/engine responder, event monitor, scenario tasks.
module tb_conv_run_sequencer;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    conv_run_if bus();

    conv_run_sequencer #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder: acks/dones one cycle after each strobe unless held; manual pulses ORed in.
    logic       auto_en   = 1'b1;
    logic [2:0] hold      = 3'b000;
    logic       man_pe    = 1'b0;
    logic       man_sa3   = 1'b0;
    logic       stray_sa2 = 1'b0;
    logic       pend_cap = 1'b0, pend_pe = 1'b0, pend_sa3 = 1'b0, pend_sa2 = 1'b0;

    always @(posedge clk) begin
        pend_cap <= bus.run_valid_o;
        pend_pe  <= bus.pe_start;
        pend_sa3 <= bus.sa3_start;
        pend_sa2 <= bus.sa2_start;
    end

    always_comb begin
        bus.done_capture = auto_en && pend_cap;
        bus.pe_done      = (auto_en && pend_pe  && !hold[0]) || man_pe;
        bus.sa3_done     = (auto_en && pend_sa3 && !hold[1]) || man_sa3;
        bus.sa2_done     = (auto_en && pend_sa2 && !hold[2]) || stray_sa2;
    end

    // Monitor
    int         n_cap = 0, n_done = 0, n_excl = 0, cap_cyc = -1, done_cyc = -1;
    logic [1:0] st_code[$];
    int         st_cyc[$];
    logic [1:0] ae_log[$];
    logic [1:0] ae_prev = 2'd0;
    logic [1:0] exp_q[$];
    int         exp_cyc[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.run_valid_o) begin n_cap++; cap_cyc = cyc; end
            if (bus.pe_start)  begin st_code.push_back(2'd1); st_cyc.push_back(cyc); end
            if (bus.sa3_start) begin st_code.push_back(2'd2); st_cyc.push_back(cyc); end
            if (bus.sa2_start) begin st_code.push_back(2'd3); st_cyc.push_back(cyc); end
            if (bus.run_done) begin n_done++; done_cyc = cyc; end
            if ($countones({bus.run_valid_o, bus.pe_start, bus.sa3_start, bus.sa2_start}) > 1) n_excl++;
            if (bus.active_engine != 2'd0 && bus.active_engine != ae_prev) ae_log.push_back(bus.active_engine);
            ae_prev = bus.active_engine;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs;
        n_cap = 0; n_done = 0; cap_cyc = -1; done_cyc = -1;
        st_code.delete(); st_cyc.delete(); ae_log.delete(); ae_prev = 2'd0;
    endtask

    task automatic do_start(input logic [2:0] en);
        bus.engine_en = en;
        bus.start     = 1'b1;
        step();
        bus.start     = 1'b0;
        bus.engine_en = 3'b000;
    endtask

    task automatic wait_idle(input int budget, output int n);
        n = 0;
        while (bus.busy && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.engine_en = 3'b000;
        repeat (3) step();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if ({bus.run_valid_o, bus.pe_start, bus.sa3_start, bus.sa2_start} !== 4'b0000) begin
            errors++; $display("FAIL reset_strobes got=%b exp=0000", {bus.run_valid_o, bus.pe_start, bus.sa3_start, bus.sa2_start}); end
        checks++; if (bus.active_engine !== 2'd0) begin errors++; $display("FAIL reset_active got=%0d exp=0", bus.active_engine); end
        checks++; if ({bus.run_done, bus.timeout_err} !== 2'b00) begin errors++; $display("FAIL reset_done_err got=%b exp=00", {bus.run_done, bus.timeout_err}); end
        checks++; if (bus.fsm_state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", bus.fsm_state); end
        reset = 1'b0;
        step();
        clear_logs();
    endtask

    task automatic test_all_engines;
        int c1, n;
        clear_logs();
        do_start(3'b111);
        c1 = cyc;
        wait_idle(40, n);
        checks++; if (n !== 9) begin errors++; $display("FAIL all_busy_len got=%0d exp=9", n); end
        checks++; if (n_cap !== 1 || cap_cyc !== c1) begin errors++; $display("FAIL all_capture got=%0d@%0d exp=1@%0d", n_cap, cap_cyc, c1); end
        exp_q = '{2'd1, 2'd2, 2'd3};
        exp_cyc = '{c1 + 2, c1 + 4, c1 + 6};
        checks++; if (st_code.size() !== 3) begin errors++; $display("FAIL all_start_count got=%0d exp=3", st_code.size()); end
        for (int i = 0; i < 3 && i < st_code.size(); i++) begin
            checks++; if (st_code[i] !== exp_q[i] || st_cyc[i] !== exp_cyc[i]) begin
                errors++; $display("FAIL all_start_%0d got=%0d@%0d exp=%0d@%0d", i, st_code[i], st_cyc[i], exp_q[i], exp_cyc[i]); end
        end
        checks++; if (n_done !== 1 || done_cyc !== c1 + 8) begin errors++; $display("FAIL all_run_done got=%0d@%0d exp=1@%0d", n_done, done_cyc, c1 + 8); end
        checks++; if (ae_log.size() !== 3 || ae_log[0] !== 2'd1 || ae_log[1] !== 2'd2 || ae_log[2] !== 2'd3) begin
            errors++; $display("FAIL all_active_seq got_size=%0d exp=1,2,3", ae_log.size()); end
        checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL all_timeout_err got=%b exp=0", bus.timeout_err); end
    endtask

    task automatic test_skip_middle;
        int c1, n;
        clear_logs();
        do_start(3'b101);
        c1 = cyc;
        wait_idle(40, n);
        checks++; if (n !== 7) begin errors++; $display("FAIL skip_busy_len got=%0d exp=7", n); end
        exp_q = '{2'd1, 2'd3};
        exp_cyc = '{c1 + 2, c1 + 4};
        checks++; if (st_code.size() !== 2) begin errors++; $display("FAIL skip_start_count got=%0d exp=2", st_code.size()); end
        for (int i = 0; i < 2 && i < st_code.size(); i++) begin
            checks++; if (st_code[i] !== exp_q[i] || st_cyc[i] !== exp_cyc[i]) begin
                errors++; $display("FAIL skip_start_%0d got=%0d@%0d exp=%0d@%0d", i, st_code[i], st_cyc[i], exp_q[i], exp_cyc[i]); end
        end
        checks++; if (ae_log.size() !== 2 || ae_log[0] !== 2'd1 || ae_log[1] !== 2'd3) begin
            errors++; $display("FAIL skip_active_seq got_size=%0d exp=1,3", ae_log.size()); end
        checks++; if (n_done !== 1 || done_cyc !== c1 + 6) begin errors++; $display("FAIL skip_run_done got=%0d@%0d exp=1@%0d", n_done, done_cyc, c1 + 6); end
    endtask

    task automatic test_empty_mask;
        int c1, n;
        clear_logs();
        do_start(3'b000);
        c1 = cyc;
        wait_idle(40, n);
        checks++; if (n !== 3) begin errors++; $display("FAIL empty_busy_len got=%0d exp=3", n); end
        checks++; if (n_cap !== 1 || cap_cyc !== c1) begin errors++; $display("FAIL empty_capture got=%0d@%0d exp=1@%0d", n_cap, cap_cyc, c1); end
        checks++; if (st_code.size() !== 0) begin errors++; $display("FAIL empty_no_starts got=%0d exp=0", st_code.size()); end
        checks++; if (n_done !== 1 || done_cyc !== c1 + 2) begin errors++; $display("FAIL empty_run_done got=%0d@%0d exp=1@%0d", n_done, done_cyc, c1 + 2); end
    endtask

    task automatic test_timeout;
        int c1, n;
        clear_logs();
        hold = 3'b010;
        do_start(3'b111);
        c1 = cyc;
        wait_idle(60, n);
        checks++; if (n !== 13) begin errors++; $display("FAIL to_busy_len got=%0d exp=13", n); end
        checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL to_err_set got=%b exp=1", bus.timeout_err); end
        checks++; if (bus.active_engine !== 2'd0) begin errors++; $display("FAIL to_active got=%0d exp=0", bus.active_engine); end
        checks++; if (st_code.size() !== 2 || st_code[0] !== 2'd1 || st_code[1] !== 2'd2) begin
            errors++; $display("FAIL to_starts got_size=%0d exp=1,2 only", st_code.size()); end
        checks++; if (n_done !== 0) begin errors++; $display("FAIL to_no_run_done got=%0d exp=0", n_done); end
        hold = 3'b000;
        clear_logs();
        // Restart in the very first idle cycle after the abort.
        do_start(3'b001);
        c1 = cyc;
        checks++; if (bus.timeout_err !== 1'b0 || bus.run_valid_o !== 1'b1) begin
            errors++; $display("FAIL to_restart got_err=%b got_rv=%b exp=0,1", bus.timeout_err, bus.run_valid_o); end
        wait_idle(40, n);
        checks++; if (n_done !== 1 || done_cyc !== c1 + 4) begin errors++; $display("FAIL to_rerun_done got=%0d@%0d exp=1@%0d", n_done, done_cyc, c1 + 4); end
    endtask

    task automatic test_stray_and_busy_start;
        int c1, n;
        clear_logs();
        do_start(3'b011);
        c1 = cyc;
        bus.start = 1'b1;
        bus.engine_en = 3'b100;
        stray_sa2 = 1'b1;
        hold = 3'b001;
        repeat (5) step();
        man_pe = 1'b1;
        step();
        man_pe = 1'b0;
        wait_idle(40, n);
        n = n + 6;
        bus.start = 1'b0;
        stray_sa2 = 1'b0;
        hold = 3'b000;
        checks++; if (n !== 9) begin errors++; $display("FAIL stray_busy_len got=%0d exp=9", n); end
        exp_q = '{2'd1, 2'd2};
        exp_cyc = '{c1 + 2, c1 + 6};
        checks++; if (st_code.size() !== 2) begin errors++; $display("FAIL stray_start_count got=%0d exp=2", st_code.size()); end
        for (int i = 0; i < 2 && i < st_code.size(); i++) begin
            checks++; if (st_code[i] !== exp_q[i] || st_cyc[i] !== exp_cyc[i]) begin
                errors++; $display("FAIL stray_start_%0d got=%0d@%0d exp=%0d@%0d", i, st_code[i], st_cyc[i], exp_q[i], exp_cyc[i]); end
        end
        checks++; if (n_done !== 1 || done_cyc !== c1 + 8) begin errors++; $display("FAIL stray_run_done got=%0d@%0d exp=1@%0d", n_done, done_cyc, c1 + 8); end
        checks++; if (n_cap !== 1) begin errors++; $display("FAIL stray_capture_count got=%0d exp=1", n_cap); end
        step();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stray_not_requeued got=%b exp=0", bus.busy); end
    endtask

    task automatic test_reset_mid_run;
        int n_before;
        clear_logs();
        hold = 3'b010;
        do_start(3'b111);
        repeat (5) step();
        checks++; if (bus.active_engine !== 2'd2 || bus.fsm_state !== 3'd4) begin
            errors++; $display("FAIL rst_pre_state got_ae=%0d got_st=%0d exp=2,4", bus.active_engine, bus.fsm_state); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if ({bus.busy, bus.run_valid_o, bus.pe_start, bus.sa3_start, bus.sa2_start, bus.run_done, bus.timeout_err} !== 7'd0
                      || bus.active_engine !== 2'd0) begin
            errors++; $display("FAIL rst_outputs got_busy=%b got_ae=%0d exp=0,0", bus.busy, bus.active_engine); end
        n_before = st_code.size();
        man_sa3 = 1'b1;
        step();
        man_sa3 = 1'b0;
        hold = 3'b000;
        repeat (4) step();
        checks++; if (st_code.size() !== n_before || bus.busy !== 1'b0) begin
            errors++; $display("FAIL rst_late_done got_starts=%0d got_busy=%b exp=%0d,0", st_code.size(), bus.busy, n_before); end
        checks++; if (n_done !== 0) begin errors++; $display("FAIL rst_no_run_done got=%0d exp=0", n_done); end
    endtask

    task automatic test_exclusive;
        checks++; if (n_excl !== 0) begin errors++; $display("FAIL strobe_exclusive got=%0d exp=0", n_excl); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.engine_en = 3'b000;
        test_reset();
        test_all_engines();
        test_skip_middle();
        test_empty_mask();
        test_timeout();
        test_stray_and_busy_start();
        test_reset_mid_run();
        test_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
